elastic_stage_register: RTL
===========================

// Module: elastic_stage_register
// PURPOSE
//   Parametrised elastic pipeline stage. It generalises the fixed-width IF/ID
//   stall/flush register into a valid/ready handshaked stage with a 2-entry
//   skid buffer.
//   Any stage boundary (IF/ID, ID/EX, ...) can instantiate it with its own
//   payload width and bubble encoding.
//   - Stalls propagate upstream by registered ready, so there is no
//     combinational ready path.
//   - Flush squashes all held payloads and presents a bubble.
// PARAMETERS
//   DATA_W   32            payload width in bits (>=1)
//   BUBBLE   32'h0000_0013 value on Out_Data whenever Out_Valid=0
//                          (NOP encoding), width DATA_W
//   CNT_W    16            width of saturating stall-cycle counter (>=1)
// PORTS
//   CLK          in   1       clock, all state on rising edge
//   RST_N        in   1       asynchronous, active-low reset
//   Flush        in   1       synchronous squash, highest priority after reset
//   In_Valid     in   1       upstream payload valid
//   In_Ready     out  1       stage can accept (registered)
//   In_Data      in   DATA_W  upstream payload
//   Out_Valid    out  1       payload valid to downstream
//   Out_Ready    in   1       downstream accepts
//   Out_Data     out  DATA_W  payload to downstream
//   Stall_Count  out  CNT_W   cycles with Out_Valid=1 and Out_Ready=0, saturating
// BEHAVIOUR
//   Reset (RST_N=0, async, any time, including mid-transfer):
//   - state=EMPTY, Out_Valid=0, Out_Data=BUBBLE.
//   - In_Ready=0 while RST_N=0, In_Ready=1 from the first edge after release.
//   - Stall_Count=0, skid contents discarded.
//   Storage: main register (drives Out_Data) and skid register (hidden).
//   Handshake rules:
//   - in_xfer  = In_Valid & In_Ready.
//   - out_xfer = Out_Valid & Out_Ready.
//   - Out_Valid=(state!=EMPTY).
//   - In_Ready=(state!=FULL), a flop output.
//   - Out_Data/Out_Valid held stable while Out_Valid=1 and Out_Ready=0.
//   State machine (evaluated when Flush=0):
//   - EMPTY: in_xfer -> ONE, main<=In_Data. Otherwise stay.
//   - ONE:
//       in_xfer & out_xfer  -> ONE, main<=In_Data.
//       in_xfer & !out_xfer -> FULL, skid<=In_Data.
//       !in_xfer & out_xfer -> EMPTY, main<=BUBBLE.
//       neither             -> stay.
//   - FULL: In_Ready=0.
//       out_xfer  -> ONE, main<=skid.
//       otherwise -> stay.
//   Flush=1 at an edge:
//   - Next state EMPTY, main<=BUBBLE, skid dropped.
//   - Any in_xfer or out_xfer in that same cycle is ignored. Upstream
//     drops the beat, as the flush source already redirects fetch.
//   Invariant: Out_Data==BUBBLE whenever Out_Valid=0.
//   Latency and throughput:
//   - 1 cycle In_Data->Out_Data.
//   - Full throughput of 1 beat per cycle with Out_Ready held high.
//   - Ordering is strictly FIFO, with no duplication or loss except on flush.
//   Stall_Count:
//   - Increments by 1 each edge with Out_Valid & !Out_Ready.
//   - Saturates at 2^CNT_W-1 and holds.
//   - Not cleared by Flush, only by reset.
// TESTING
//   1 Reset: RST_N=0 mid-stream with FULL ->
//     immediately Out_Valid=0, Out_Data=32'h13, In_Ready=0, Stall_Count=0.
//   2 Streaming: Out_Ready=1, In_Valid=1, data 1,2,3,4 on consecutive cycles ->
//     Out_Data 1,2,3,4 one cycle later, In_Ready constantly 1.
//   3 Backpressure: send A,B with Out_Ready=0 ->
//     FULL, In_Ready=0, Out_Data=A held.
//     Raise Out_Ready -> A then B, then Out_Valid=0, Out_Data=32'h13.
//     Stall_Count equals the number of Out_Ready=0 cycles with Out_Valid=1.
//   4 Flush: FULL with A,B, assert Flush together with In_Valid=1 (C) and
//     Out_Ready=1 -> next cycle Out_Valid=0, Out_Data=32'h13, In_Ready=1.
//     A, B and C are never emitted.
//   5 Saturation: CNT_W=3, Out_Valid=1, Out_Ready=0 for 10 cycles ->
//     Stall_Count=7 and holds. Then Flush -> Stall_Count stays 7.
//   6 Width: DATA_W=97 with a random FIFO scoreboard over 10k cycles and
//     random valid/ready/flush -> zero mismatches, and BUBBLE shown when idle.

Source files
------------

// File: rtl/elastic_stage_register.sv
// Elastic valid/ready pipeline stage with a main register, a hidden skid register,
// a registered In_Ready (no combinational ready path) and a saturating stall counter.
module elastic_stage_register #(
  parameter int unsigned        DATA_W = 32,
  parameter logic [DATA_W-1:0]  BUBBLE = DATA_W'(32'h0000_0013),
  parameter int unsigned        CNT_W  = 16
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              Flush,
  input  logic              In_Valid,
  output logic              In_Ready,
  input  logic [DATA_W-1:0] In_Data,
  output logic              Out_Valid,
  input  logic              Out_Ready,
  output logic [DATA_W-1:0] Out_Data,
  output logic [CNT_W-1:0]  Stall_Count
);

  typedef enum logic [1:0] {StEmpty, StOne, StFull} state_e;

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   main_q, main_d;
  logic [DATA_W-1:0]   skid_q, skid_d;
  logic                ready_q, ready_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                in_xfer, out_xfer;

  assign Out_Valid   = (state_q != StEmpty);
  assign Out_Data    = main_q;
  assign In_Ready    = ready_q;
  assign Stall_Count = cnt_q;

  always_comb begin
    state_d  = state_q;
    main_d   = main_q;
    skid_d   = skid_q;
    in_xfer  = In_Valid & ready_q;
    out_xfer = Out_Valid & Out_Ready;

    if (Flush) begin
      // Beats offered or accepted in the flush cycle are dropped.
      state_d = StEmpty;
      main_d  = BUBBLE;
      skid_d  = BUBBLE;
    end else begin
      unique case (state_q)
        StEmpty: begin
          if (in_xfer) begin
            state_d = StOne;
            main_d  = In_Data;
          end
        end
        StOne: begin
          if (in_xfer && out_xfer) begin
            main_d = In_Data;
          end else if (in_xfer) begin
            state_d = StFull;
            skid_d  = In_Data;
          end else if (out_xfer) begin
            state_d = StEmpty;
            main_d  = BUBBLE;
          end
        end
        StFull: begin
          if (out_xfer) begin
            state_d = StOne;
            main_d  = skid_q;
          end
        end
        default: begin
          state_d = StEmpty;
          main_d  = BUBBLE;
        end
      endcase
    end

    ready_d = (state_d != StFull);

    cnt_d = cnt_q;
    if (Out_Valid && !Out_Ready && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= StEmpty;
      main_q  <= BUBBLE;
      skid_q  <= BUBBLE;
      ready_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
      ready_q <= ready_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule
